// File: rtl/fifo_byte_packer.sv
// FIFO drain stage: pops DATA_WIDTH entries and packs LANES of them into one wide valid/ready word.
// Optional FIFO_PACKER_CHK_EN adds a sticky proto_err output for read/valid handshake violations.
module fifo_byte_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                        clk,
  input  logic                        clear_n,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_data_valid,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_count
`ifdef FIFO_PACKER_CHK_EN
  ,
  output logic                        proto_err
`endif
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned OUT_W = DATA_WIDTH * LANES;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                               state_q, state_d;
  logic [CNT_WIDTH-1:0]                 lane_cnt_q, lane_cnt_d;
  logic                                 pending_q, pending_d;
  logic                                 flush_pend_q, flush_pend_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]     lanes_q, lanes_d;
  logic                                 out_valid_d;
  logic [OUT_W-1:0]                     out_data_d;
  logic [CNT_WIDTH-1:0]                 out_count_d;
  logic [CNT_WIDTH:0]                   cnt_sum;
  logic                                 rd_c;
  logic                                 capture_c;

  // Lanes already held plus the one in flight must leave room for another read.
  assign cnt_sum = {1'b0, lane_cnt_q} + (CNT_WIDTH+1)'(pending_q);
  assign rd_c    = clear_n && (state_q == FILL) && !flush_pend_q && !fifo_empty
                   && (cnt_sum < (CNT_WIDTH+1)'(LANES));
  assign fifo_rd = rd_c;

  assign capture_c = (state_q == FILL) && fifo_data_valid && pending_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      pending_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      lanes_q      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      pending_q    <= pending_d;
      flush_pend_q <= flush_pend_d;
      lanes_q      <= lanes_d;
      out_valid    <= out_valid_d;
      out_data     <= out_data_d;
      out_count    <= out_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    pending_d    = rd_c;
    flush_pend_d = flush_pend_q;
    lanes_d      = lanes_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_count_d  = out_count;

    unique case (state_q)
      FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (capture_c) begin
          lanes_d[IDX_W'(lane_cnt_q)] = fifo_data;
          lane_cnt_d                  = lane_cnt_q + CNT_WIDTH'(1);
        end
        if (capture_c && (lane_cnt_d == CNT_WIDTH'(LANES))) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = lanes_d;
          out_count_d = CNT_WIDTH'(LANES);
        end else if (flush_pend_q && !pending_q) begin
          // Flush waits for the in-flight byte; an empty packer just drops the request.
          if (lane_cnt_q != '0) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_data_d  = lanes_q;
            out_count_d = lane_cnt_q;
          end else begin
            flush_pend_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d      = FILL;
          out_valid_d  = 1'b0;
          lane_cnt_d   = '0;
          flush_pend_d = 1'b0;
          lanes_d      = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef FIFO_PACKER_CHK_EN
  logic proto_err_d;

  // Sticky flag: a valid without a read, or a read that never returned data.
  always_comb begin
    proto_err_d = proto_err;
    if ((fifo_data_valid && !pending_q) || (pending_q && !fifo_data_valid))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) proto_err <= 1'b0;
    else          proto_err <= proto_err_d;
  end
`endif

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a queue-based model of the upstream FIFO.
// Define FIFO_PACKER_CHK_EN to also exercise the proto_err output.
module tb_fifo_byte_packer;

  logic        clk;
  logic        clear_n;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_data;
  logic        fifo_data_valid;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
`ifdef FIFO_PACKER_CHK_EN
  logic        proto_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] got_data[$];
  logic [2:0]  got_cnt[$];
  int          runs[$];
  int          rd_total;
  int          cur_run;
  int          ov_cycles;
  int          cyc;
  int          first_ov;

  fifo_byte_packer dut (
    .clk(clk),
    .clear_n(clear_n),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
`ifdef FIFO_PACKER_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_stats();
    got_data.delete();
    got_cnt.delete();
    runs.delete();
    rd_total  = 0;
    cur_run   = 0;
    ov_cycles = 0;
    cyc       = 0;
    first_ov  = -1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: observe at the falling edge, then model the FIFO answering a read.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = fifo_rd;
    if (rd_s) begin
      rd_total++;
      cur_run++;
    end else begin
      if (cur_run != 0) runs.push_back(cur_run);
      cur_run = 0;
    end
    if (out_valid) begin
      ov_cycles++;
      if (first_ov < 0) first_ov = cyc;
    end
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_cnt.push_back(out_count);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) begin
      fifo_data       = fifo_q.pop_front();
      fifo_data_valid = 1'b1;
    end else begin
      fifo_data_valid = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    fifo_empty = 1'b0;
    fifo_data = 8'h00;
    fifo_data_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_fifo_rd got %b want 0", fifo_rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 00000000", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_out_count got %0d want 0", out_count); end
`ifdef FIFO_PACKER_CHK_EN
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
`endif
    fifo_empty = 1'b1;
    @(posedge clk); #1;
    clear_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    clear_stats();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'((i << 4) | i));
    for (int i = 0; i < 14; i++) tick();
    checks++; if (first_ov !== 5) begin errors++; $display("FAIL t1_latency got %0d want 5", first_ov); end
    checks++; if (rd_total !== 8) begin errors++; $display("FAIL t1_rd_total got %0d want 8", rd_total); end
    checks++;
    if (runs.size() !== 2) begin
      errors++; $display("FAIL t1_rd_runs got %0d runs want 2", runs.size());
    end else if (runs[0] !== 4 || runs[1] !== 4) begin
      errors++; $display("FAIL t1_rd_runs got %0d,%0d want 4,4", runs[0], runs[1]);
    end
    checks++;
    if (got_data.size() !== 2) begin
      errors++; $display("FAIL t1_words got %0d want 2", got_data.size());
    end else begin
      checks++; if (got_data[0] !== 32'h44332211) begin errors++; $display("FAIL t1_word0 got %h want 44332211", got_data[0]); end
      checks++; if (got_data[1] !== 32'h88776655) begin errors++; $display("FAIL t1_word1 got %h want 88776655", got_data[1]); end
      checks++; if (got_cnt[0] !== 3'd4 || got_cnt[1] !== 3'd4) begin errors++; $display("FAIL t1_counts got %0d,%0d want 4,4", got_cnt[0], got_cnt[1]); end
    end
  endtask

  task automatic test_backpressure();
    int held;
    int bad;
    clear_stats();
    held = 0;
    bad  = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'((i << 4) | i));
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) begin
        held++;
        if (out_data !== 32'h44332211 || out_count !== 3'd4) bad++;
      end
    end
    checks++; if (held !== 11) begin errors++; $display("FAIL t2_hold_cycles got %0d want 11", held); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t2_hold_stable got %0d unstable want 0", bad); end
    checks++; if (rd_total !== 4) begin errors++; $display("FAIL t2_rd_total got %0d want 4", rd_total); end
    clear_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_data.size() !== 2) begin
      errors++; $display("FAIL t2_words got %0d want 2", got_data.size());
    end else begin
      checks++; if (got_data[0] !== 32'h44332211) begin errors++; $display("FAIL t2_word0 got %h want 44332211", got_data[0]); end
      checks++; if (got_data[1] !== 32'h88776655) begin errors++; $display("FAIL t2_word1 got %h want 88776655", got_data[1]); end
    end
  endtask

  task automatic test_flush_partial();
    int n;
    clear_stats();
    out_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    n = 0;
    while (rd_total < 3 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (rd_total !== 3) begin errors++; $display("FAIL t3_reads got %0d want 3", rd_total); end
    // Third byte is still in flight when the flush pulse arrives.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (got_data.size() !== 1) begin
      errors++; $display("FAIL t3_words got %0d want 1", got_data.size());
    end else begin
      checks++; if (got_data[0] !== 32'h00A3A2A1) begin errors++; $display("FAIL t3_data got %h want 00a3a2a1", got_data[0]); end
      checks++; if (got_cnt[0] !== 3'd3) begin errors++; $display("FAIL t3_count got %0d want 3", got_cnt[0]); end
    end
  endtask

  task automatic test_flush_idle();
    clear_stats();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (ov_cycles !== 0) begin errors++; $display("FAIL t4_no_output got %0d valid cycles want 0", ov_cycles); end
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (got_data.size() !== 1) begin
      errors++; $display("FAIL t4_after_flush_words got %0d want 1", got_data.size());
    end else if (got_data[0] !== 32'h8D7C6B5A || got_cnt[0] !== 3'd4) begin
      errors++; $display("FAIL t4_after_flush_word got %h/%0d want 8d7c6b5a/4", got_data[0], got_cnt[0]);
    end
  endtask

  task automatic test_reset_midword();
    clear_stats();
    out_ready = 1'b1;
    push(8'hE1); push(8'hE2);
    for (int i = 0; i < 4; i++) tick();
    clear_n = 1'b0;
    fifo_q.delete();
    fifo_data_valid = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    #1;
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL t5_rd_in_reset got %b want 0", fifo_rd); end
    checks++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin errors++; $display("FAIL t5_out_in_reset got %b/%0d want 0/0", out_valid, out_count); end
    tick();
    clear_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_data.size() !== 1) begin
      errors++; $display("FAIL t5_words got %0d want 1", got_data.size());
    end else begin
      checks++; if (got_data[0] !== 32'h04030201) begin errors++; $display("FAIL t5_data got %h want 04030201", got_data[0]); end
      checks++; if (got_cnt[0] !== 3'd4) begin errors++; $display("FAIL t5_count got %0d want 4", got_cnt[0]); end
    end
  endtask

  task automatic test_spurious_valid();
    clear_stats();
    out_ready = 1'b1;
`ifdef FIFO_PACKER_CHK_EN
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t6_proto_pre got %b want 0", proto_err); end
`endif
    fifo_data = 8'hFF;
    fifo_data_valid = 1'b1;
    tick();
`ifdef FIFO_PACKER_CHK_EN
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t6_proto_set got %b want 1", proto_err); end
`endif
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_data.size() !== 1) begin
      errors++; $display("FAIL t6_words got %0d want 1", got_data.size());
    end else if (got_data[0] !== 32'hC4C3C2C1 || got_cnt[0] !== 3'd4) begin
      errors++; $display("FAIL t6_word got %h/%0d want c4c3c2c1/4", got_data[0], got_cnt[0]);
    end
`ifdef FIFO_PACKER_CHK_EN
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t6_proto_sticky got %b want 1", proto_err); end
    clear_n = 1'b0;
    #2;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t6_proto_reset got %b want 0", proto_err); end
    tick();
    clear_n = 1'b1;
`endif
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_idle();
    test_reset_midword();
    test_spurious_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_byte_packer.md
Name: fifo_byte_packer

Overview:
- Read-side consumer placed directly downstream of the byte FIFO.
- Pops DATA_WIDTH-bit entries through the FIFO's rd/data_out/data_out_valid/empty interface and assembles LANES entries into one wide word.
- Presents each word on a valid/ready output port.
- Supports a flush request that emits a partial word with a byte count. It is the FIFO drain stage that feeds the wide datapath.

Parameters:
- DATA_WIDTH, 8: width of one FIFO entry (lane).
- LANES, 4: lanes per output word; must be 2 or more.
- CNT_WIDTH, 3: width of lane counter and out_count; must be able to hold the value LANES.

Ports:
- clk  in  1  single clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  empty flag from upstream FIFO.
- fifo_rd  out  1  read strobe to upstream FIFO (combinational).
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- fifo_data_valid  in  1  FIFO data_out_valid; arrives 1 cycle after an accepted read.
- flush  in  1  single-cycle request to emit the partial word.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_data  out  DATA_WIDTH*LANES  packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest entry.
- out_count  out  CNT_WIDTH  number of valid lanes in out_data (1..LANES).

Behaviour:
- Reset (clear_n low, asynchronous):
  - state=FILL, lane_cnt=0, pending=0, flush_pend=0.
  - out_valid=0, out_data=0, out_count=0.
  - fifo_rd is forced 0 while clear_n is low.
- pending: registered copy of fifo_rd from the previous cycle. At most one read is in flight.
- fifo_rd = clear_n && state==FILL && !flush_pend && !fifo_empty && (lane_cnt + pending < LANES).
  - Back-to-back reads are allowed.
- Capture: when fifo_data_valid is high in FILL, fifo_data is written to lane[lane_cnt], lane_cnt increments, and pending clears.
  - A fifo_data_valid with pending=0 is dropped.
- FILL->HOLD when either:
  - the capture brings lane_cnt to LANES: at the next edge out_valid=1 and out_count=LANES; or
  - flush_pend=1, pending=0 and lane_cnt>0: out_count=lane_cnt, and unused lanes of out_data are 0.
- Latency: last lane's fifo_data_valid in cycle k -> out_valid high in cycle k+1.
- HOLD:
  - out_data and out_count are stable and fifo_rd=0 while out_ready is low.
  - On out_valid && out_ready: out_valid=0, lane_cnt=0, flush_pend=0, lanes cleared, return to FILL.
  - A new word can be presented no sooner than 2 cycles after the handshake: read, then capture, then register.
- Flush:
  - A flush pulse in FILL sets flush_pend and stops new reads.
  - An in-flight byte is still captured before the partial word is emitted.
  - If lane_cnt==0 and pending==0 with flush_pend set, flush_pend clears with no output.
  - Flush while in HOLD is ignored.
- A FIFO going empty mid-word just stalls; there is no timeout.
- Reset mid-operation discards the partial word and any in-flight read. The upstream FIFO must be reset in the same cycle.

Optional Feature:
- Macro FIFO_PACKER_CHK_EN.
- Defined:
  - Adds output port proto_err (1 bit, reset 0, sticky until clear_n).
  - proto_err is set the cycle after fifo_data_valid=1 with pending=0, or after pending=1 with fifo_data_valid=0.
  - Packing behaviour is unchanged.
- Undefined: port absent. Unexpected valids are silently dropped; a missing valid clears pending and loses that lane.

Test Plan:
1. FIFO preloaded with 0x11..0x88, out_ready=1 -> two words, 0x44332211 then 0x88776655, out_count=4 each, fifo_rd high 4 consecutive cycles per word.
2. Same preload, out_ready=0 for 10 cycles -> 0x44332211 held stable, exactly 4 fifo_rd pulses total; raise out_ready -> 0x88776655 follows.
3. Push 0xA1,0xA2,0xA3 then flush -> out_data=0x00A3A2A1, out_count=3; flush issued while third read in flight still yields count 3.
4. Flush with packer idle, FIFO empty -> no out_valid for 10 cycles, flush_pend clear.
5. Two bytes captured, clear_n low 1 cycle (FIFO also reset), then push 0x01..0x04 -> out_data=0x04030201, count 4.
6. With FIFO_PACKER_CHK_EN, force fifo_data_valid=1 with no prior fifo_rd -> proto_err=1 next cycle, stays 1 until reset; no lane captured.
